// File: rtl/router_term_fifo.sv
// Per-terminal ingress FIFO feeding a mesh router input port.
// Show-ahead head register view, count-based full/empty, sticky error flags.
module router_term_fifo #(
    parameter int unsigned PCK_SZ = 40,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [PCK_SZ-1:0] data_in,
    output logic              full,
    output logic [PCK_SZ-1:0] data_out_i_in,
    output logic              pndng_i_in,
    input  logic              popin,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PCK_SZ-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic              w_pop_ok;
    logic              w_push_ok;
    logic              w_drop;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  w_drop_nxt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);
    assign w_pop_ok  = popin & ~w_empty;
    // When full, a concurrent accepted pop frees the slot the push lands in.
    assign w_push_ok = push & (~w_full | w_pop_ok);
    assign w_drop    = push & ~w_push_ok;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (w_drop && (r_drop_cnt != CNT_MAX)) begin
            w_drop_nxt = r_drop_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_count    <= w_count_nxt;
            r_drop_cnt <= w_drop_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (popin && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    assign full          = w_full;
    assign pndng_i_in    = ~w_empty;
    assign data_out_i_in = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count         = r_count;
    assign drop_cnt      = r_drop_cnt;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule

// File: tb/tb_router_term_fifo.sv
// Scoreboard bench for router_term_fifo: queue reference model, decoupled pop monitor.
module tb_router_term_fifo;

    localparam int unsigned PCK_SZ = 40;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int          SAT    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              push = 1'b0;
    logic [PCK_SZ-1:0] data_in = '0;
    logic              full;
    logic [PCK_SZ-1:0] data_out_i_in;
    logic              pndng_i_in;
    logic              popin = 1'b0;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  drop_cnt;
    logic              overflow;
    logic              underflow;

    router_term_fifo #(
        .PCK_SZ (PCK_SZ),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .data_in       (data_in),
        .full          (full),
        .data_out_i_in (data_out_i_in),
        .pndng_i_in    (pndng_i_in),
        .popin         (popin),
        .count         (count),
        .drop_cnt      (drop_cnt),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: contents of the FIFO and the packets expected out, in order.
    logic [PCK_SZ-1:0] mq[$];
    logic [PCK_SZ-1:0] exp_q[$];
    int                m_drop;
    bit                m_over;
    bit                m_under;
    int                checks = 0;
    int                errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [PCK_SZ-1:0] rnd_pkt();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return w[PCK_SZ-1:0];
    endfunction

    // Monitor: each accepted pop must present the next expected packet.
    always @(negedge clk) begin
        if (!reset && popin && pndng_i_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_data: got %0h expected none at %0t", data_out_i_in, $time);
            end else begin
                chk("pop_data", 64'(data_out_i_in), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_state(string tag);
        logic [PCK_SZ-1:0] head;
        head = (mq.size() != 0) ? mq[0] : '0;
        chk({tag, ".count"}, 64'(count), 64'(mq.size()));
        chk({tag, ".pndng"}, 64'(pndng_i_in), 64'(mq.size() != 0));
        chk({tag, ".full"}, 64'(full), 64'(mq.size() == DEPTH));
        chk({tag, ".head"}, 64'(data_out_i_in), 64'(head));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_over));
        chk({tag, ".underflow"}, 64'(underflow), 64'(m_under));
        chk({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
    endtask

    // Called just after a rising edge; drives one cycle and checks the result.
    task automatic cycle(input bit p, input logic [PCK_SZ-1:0] d, input bit q, input string tag);
        bit pop_ok;
        bit push_ok;
        push    = p;
        data_in = d;
        popin   = q;
        pop_ok  = q && (mq.size() != 0);
        push_ok = p && ((mq.size() < DEPTH) || pop_ok);
        if (pop_ok) exp_q.push_back(mq.pop_front());
        if (push_ok) mq.push_back(d);
        if (p && !push_ok) begin
            m_over = 1'b1;
            if (m_drop < SAT) m_drop++;
        end
        if (q && !pop_ok) m_under = 1'b1;
        @(posedge clk);
        #1;
        push  = 1'b0;
        popin = 1'b0;
        check_state(tag);
    endtask

    task automatic model_clear();
        mq.delete();
        m_drop  = 0;
        m_over  = 1'b0;
        m_under = 1'b0;
    endtask

    task automatic do_reset();
        #3;
        reset = 1'b1;
        model_clear();
        #4;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [PCK_SZ-1:0] pk [10];

    initial begin
        model_clear();
        for (int i = 0; i < 10; i++) pk[i] = rnd_pkt();
        #2;
        check_state("reset");
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single push, then hold with no pop.
        cycle(1'b1, 40'hA5_0000_0001, 1'b0, "single");
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, "hold");

        // Fill, overflow, drain.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, pk[i], 1'b0, "fill");
        cycle(1'b1, pk[4], 1'b0, "overflow");
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, "drain");

        // Full with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, pk[i], 1'b0, "fill2");
        cycle(1'b1, pk[4], 1'b1, "full_pushpop");
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, "drain2");

        // Underflow cases.
        do_reset();
        cycle(1'b0, '0, 1'b1, "underflow_pop");
        cycle(1'b1, pk[5], 1'b1, "empty_pushpop");

        // Steady push+pop at occupancy 2 across several pointer wraps.
        do_reset();
        cycle(1'b1, pk[6], 1'b0, "prefill");
        cycle(1'b1, pk[7], 1'b0, "prefill");
        for (int i = 0; i < 3 * DEPTH; i++) cycle(1'b1, rnd_pkt(), 1'b1, "stream");

        // Reset asserted between edges with count=3 and overflow set.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, pk[i], 1'b0, "pre_rst");
        cycle(1'b0, '0, 1'b1, "pre_rst_pop");
        #3;
        reset = 1'b1;
        model_clear();
        #1;
        check_state("async_rst");
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, pk[9], 1'b0, "post_rst");

        // Randomized traffic, biased to reach full and empty.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit bp;
            bit bq;
            bp = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 35));
            bq = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 70));
            cycle(bp, rnd_pkt(), bq, "random");
        end

        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, "idle");
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
